// File: rtl/bus_uart.sv
// bus_uart: memory-mapped 8N1 serial port on the 6502 bus.
// TX holding register + shifter, 2-flop RX synchronizer, RX deserializer,
// 4-deep RX FIFO, sticky OVR/FERR flags and a registered active-low IRQ.
module bus_uart #(
  parameter int unsigned DIV = 434
) (
  input  logic       CLOCK_50,
  input  logic       res_n,
  input  logic       cpu_phi,
  input  logic       cs,
  input  logic [1:0] adr,
  input  logic       rw,
  input  logic [7:0] dbi,
  output logic [7:0] dbo,
  output logic       irq_n,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // Bus side
  logic       r_phi_d;
  logic       w_strobe, w_wr, w_rd, w_pop, w_stat_rd;
  logic [1:0] r_ctrl;
  logic       r_irq_n;
  logic       r_ovr, r_ferr;

  // TX side
  tx_state_t  r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [2:0] r_tx_idx;
  logic [7:0] r_tx_shift;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_txd, w_txd_next;
  logic       w_tx_done, w_tx_load;

  // RX side
  rx_state_t  r_rx_state, w_rx_next;
  logic       r_rx_s1, r_rx_s2, w_rxs;
  logic [15:0] r_rx_cnt;
  logic [2:0] r_rx_idx;
  logic [7:0] r_rx_shift;
  logic       w_rx_tick, w_push, w_ferr_set;

  // FIFO
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  logic       w_full, w_empty, w_push_ok, w_ovr_set;

  assign w_strobe  = r_phi_d & ~cpu_phi;
  assign w_wr      = w_strobe & cs & ~rw;
  assign w_rd      = w_strobe & cs & rw;
  assign w_empty   = (r_cnt == 3'd0);
  assign w_full    = (r_cnt == 3'd4);
  assign w_pop     = w_rd & (adr == 2'd0) & ~w_empty;
  assign w_stat_rd = w_rd & (adr == 2'd1);
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;
  assign w_rxs     = r_rx_s2;
  assign w_tx_done = (r_tx_cnt == DIV_M1);
  assign txd       = r_txd;
  assign irq_n     = r_irq_n;

  // Bus registers: phase delay, control, sticky flags, interrupt
  always_ff @(posedge CLOCK_50) begin
    if (!res_n) begin
      r_phi_d <= 1'b0;
      r_ctrl  <= '0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_irq_n <= 1'b1;
    end else begin
      r_phi_d <= cpu_phi;
      if (w_wr && adr == 2'd2) r_ctrl <= dbi[1:0];
      // a flag event on the same strobe as a STATUS read survives the clear
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (w_stat_rd) r_ovr <= 1'b0;
      if (w_ferr_set)     r_ferr <= 1'b1;
      else if (w_stat_rd) r_ferr <= 1'b0;
      r_irq_n <= ~((r_ctrl[0] & ~w_empty) | (r_ctrl[1] & ~r_hold_full));
    end
  end

  // Read-data mux, valid only while selected
  always_comb begin
    dbo = '0;
    if (cs) begin
      case (adr)
        2'd0:    dbo = w_empty ? 8'h00 : r_fifo[r_rp];
        2'd1:    dbo = {~r_irq_n, 2'b00, r_ferr, r_ovr, (r_tx_state != TX_IDLE),
                        ~r_hold_full, ~w_empty};
        2'd2:    dbo = {6'b0, r_ctrl};
        default: dbo = '0;
      endcase
    end
  end

  // TX next state and next serial level
  always_comb begin
    w_tx_next  = r_tx_state;
    w_tx_load  = 1'b0;
    w_txd_next = r_txd;
    case (r_tx_state)
      TX_IDLE: begin
        w_txd_next = 1'b1;
        if (r_hold_full) begin
          w_tx_load  = 1'b1;
          w_tx_next  = TX_START;
          w_txd_next = 1'b0;
        end
      end
      TX_START: if (w_tx_done) begin
        w_tx_next  = TX_DATA;
        w_txd_next = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_done) begin
        if (r_tx_idx == 3'd7) begin
          w_tx_next  = TX_STOP;
          w_txd_next = 1'b1;
        end else begin
          w_txd_next = r_tx_shift[1];
        end
      end
      TX_STOP: if (w_tx_done) begin
        // chain straight into the next start bit so frames are gap-free
        if (r_hold_full) begin
          w_tx_load  = 1'b1;
          w_tx_next  = TX_START;
          w_txd_next = 1'b0;
        end else begin
          w_tx_next  = TX_IDLE;
          w_txd_next = 1'b1;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // TX state, bit timer, shifter and holding register
  always_ff @(posedge CLOCK_50) begin
    if (!res_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_idx    <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_txd      <= w_txd_next;
      if (r_tx_state == TX_IDLE || w_tx_done) r_tx_cnt <= '0;
      else                                    r_tx_cnt <= r_tx_cnt + 16'd1;
      if (r_tx_state == TX_DATA && w_tx_done) r_tx_idx <= r_tx_idx + 3'd1;
      if (w_tx_load) begin
        r_tx_shift  <= r_hold;
        r_hold_full <= 1'b0;
      end else if (r_tx_state == TX_DATA && w_tx_done) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
      end
      if (w_wr && adr == 2'd0 && !r_hold_full) begin
        r_hold      <= dbi;
        r_hold_full <= 1'b1;
      end
    end
  end

  // RX next state and sample events
  always_comb begin
    w_rx_next  = r_rx_state;
    w_rx_tick  = 1'b0;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (!w_rxs) w_rx_next = RX_START;
      RX_START: if (r_rx_cnt == HALF_M1) begin
        w_rx_tick = 1'b1;
        w_rx_next = w_rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == DIV_M1) begin
        w_rx_tick = 1'b1;
        if (r_rx_idx == 3'd7) w_rx_next = RX_STOP;
      end
      RX_STOP: if (r_rx_cnt == DIV_M1) begin
        w_rx_tick = 1'b1;
        if (w_rxs) begin
          w_push    = 1'b1;
          w_rx_next = RX_IDLE;
        end else begin
          w_ferr_set = 1'b1;
          w_rx_next  = RX_BREAK;
        end
      end
      RX_BREAK: if (w_rxs) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // RX synchronizer, state, bit timer and deserializer
  always_ff @(posedge CLOCK_50) begin
    if (!res_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
      if (r_rx_state == RX_IDLE || r_rx_state == RX_BREAK || w_rx_tick) r_rx_cnt <= '0;
      else                                                              r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {w_rxs, r_rx_shift[7:1]};
        r_rx_idx   <= r_rx_idx + 3'd1;
      end
    end
  end

  // RX FIFO storage, pointers and occupancy
  always_ff @(posedge CLOCK_50) begin
    if (!res_n) begin
      for (int unsigned i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wp] <= r_rx_shift;
        r_wp         <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// tb_bus_uart: directed, table-driven checks of the bus_uart register map,
// TX framing, RX/FIFO behaviour, error flags and interrupt timing (DIV = 8).
module tb_bus_uart;

  localparam int DIV   = 8;
  localparam int CAP_N = 176;

  logic       CLOCK_50 = 1'b0;
  logic       res_n    = 1'b0;
  logic       cpu_phi  = 1'b0;
  logic       cs       = 1'b0;
  logic [1:0] adr      = 2'd0;
  logic       rw       = 1'b1;
  logic [7:0] dbi      = 8'h00;
  logic [7:0] dbo;
  logic       irq_n;
  logic       txd;
  logic       rxd      = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  bus_uart #(.DIV(DIV)) dut (
    .CLOCK_50(CLOCK_50), .res_n(res_n), .cpu_phi(cpu_phi), .cs(cs),
    .adr(adr), .rw(rw), .dbi(dbi), .dbo(dbo), .irq_n(irq_n),
    .txd(txd), .rxd(rxd)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       wr;
    logic [1:0] adr;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [34];

  // TX capture: one txd sample just after every rising edge while enabled
  logic cap [CAP_N];
  int   cap_idx = 0;
  logic cap_en  = 1'b0;
  always @(posedge CLOCK_50) begin
    #1;
    if (cap_en && cap_idx < CAP_N) begin
      cap[cap_idx] = txd;
      cap_idx++;
    end
  end

  logic rx_hist  [100];
  logic irq_hist [100];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic w, input logic [1:0] a,
                      input logic [7:0] d, input logic [7:0] e);
    vecs[i].wr = w; vecs[i].adr = a; vecs[i].wd = d; vecs[i].exp = e;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLOCK_50); cs = 1'b1; rw = 1'b0; adr = a; dbi = d; cpu_phi = 1'b1;
    @(negedge CLOCK_50); cpu_phi = 1'b0;
    @(negedge CLOCK_50); cs = 1'b0; rw = 1'b1; dbi = 8'h00;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge CLOCK_50); cs = 1'b1; rw = 1'b1; adr = a; cpu_phi = 1'b1;
    @(negedge CLOCK_50); cpu_phi = 1'b0; d = dbo;
    @(negedge CLOCK_50); cs = 1'b0;
  endtask

  task automatic apply(input int lo, input int hi, input string grp);
    logic [7:0] d;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].adr, vecs[i].wd);
      else begin
        bus_rd(vecs[i].adr, d);
        check($sformatf("%s[%0d] adr%0d", grp, i, vecs[i].adr), d, vecs[i].exp);
      end
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input logic stopb, input int k);
    int pos;
    pos = k / DIV;
    if (pos == 0)      return 1'b0;
    else if (pos == 9) return stopb;
    else               return b[pos-1];
  endfunction

  // drives one frame; rxd is left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge CLOCK_50); rxd = fbit(b, stopb, k);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic       e;
    int         first;

    // reset / register map
    setv(0, 0, 2'd1, 8'h00, 8'h02);
    setv(1, 0, 2'd2, 8'h00, 8'h00);
    setv(2, 0, 2'd0, 8'h00, 8'h00);
    setv(3, 0, 2'd3, 8'h00, 8'h00);
    setv(4, 1, 2'd2, 8'hFF, 8'h00);
    setv(5, 0, 2'd2, 8'h00, 8'h03);
    setv(6, 1, 2'd3, 8'hAA, 8'h00);
    setv(7, 0, 2'd3, 8'h00, 8'h00);
    setv(8, 1, 2'd2, 8'h00, 8'h00);
    setv(9, 0, 2'd2, 8'h00, 8'h00);
    setv(10, 0, 2'd1, 8'h00, 8'h02);
    // overrun after 5 frames
    setv(11, 0, 2'd1, 8'h00, 8'h0B);
    setv(12, 0, 2'd1, 8'h00, 8'h03);
    setv(13, 0, 2'd0, 8'h00, 8'h01);
    setv(14, 0, 2'd0, 8'h00, 8'h02);
    setv(15, 0, 2'd0, 8'h00, 8'h03);
    setv(16, 0, 2'd0, 8'h00, 8'h04);
    setv(17, 0, 2'd0, 8'h00, 8'h00);
    setv(18, 0, 2'd1, 8'h00, 8'h02);
    // simultaneous pop and push while full
    setv(19, 0, 2'd1, 8'h00, 8'h03);
    setv(20, 0, 2'd0, 8'h00, 8'h02);
    setv(21, 0, 2'd0, 8'h00, 8'h03);
    setv(22, 0, 2'd0, 8'h00, 8'h04);
    setv(23, 0, 2'd0, 8'h00, 8'h05);
    setv(24, 0, 2'd0, 8'h00, 8'h00);
    // single byte 0x3C
    setv(25, 0, 2'd1, 8'h00, 8'h03);
    setv(26, 0, 2'd0, 8'h00, 8'h3C);
    setv(27, 0, 2'd0, 8'h00, 8'h00);
    setv(28, 0, 2'd1, 8'h00, 8'h02);
    // framing error
    setv(29, 0, 2'd1, 8'h00, 8'h12);
    setv(30, 0, 2'd1, 8'h00, 8'h02);
    setv(31, 0, 2'd0, 8'h00, 8'h00);
    // glitch
    setv(32, 0, 2'd1, 8'h00, 8'h02);
    setv(33, 0, 2'd0, 8'h00, 8'h00);

    // reset
    res_n = 1'b0;
    idle(5);
    res_n = 1'b1;
    check("reset txd", {7'b0, txd}, 8'h01);
    check("reset irq_n", {7'b0, irq_n}, 8'h01);
    check("reset dbo cs=0", dbo, 8'h00);
    apply(0, 10, "regs");

    // TX: A5 then 3C queued while busy, FF dropped while holding is full
    bus_wr(2'd0, 8'hA5);
    check("tx txd before load", {7'b0, txd}, 8'h01);
    cap_idx = 0;
    cap_en  = 1'b1;
    bus_wr(2'd0, 8'h3C);
    bus_wr(2'd0, 8'hFF);
    bus_rd(2'd1, d);
    check("tx status busy+full", d, 8'h04);
    for (int i = 0; i < 400 && cap_idx < CAP_N; i++) @(negedge CLOCK_50);
    cap_en = 1'b0;
    if (cap_idx < CAP_N) check("tx capture timeout", 8'h00, 8'h01);
    for (int k = 0; k < CAP_N; k++) begin
      if (k < 160) begin
        b = (k < 80) ? 8'hA5 : 8'h3C;
        e = fbit(b, 1'b1, k % 80);
      end else e = 1'b1;
      check($sformatf("tx txd cycle %0d", k), {7'b0, cap[k]}, {7'b0, e});
    end
    bus_rd(2'd1, d);
    check("tx status idle", d, 8'h02);

    // RX single byte
    send_frame(8'h3C, 1'b1);
    idle(10);
    apply(25, 28, "rx3c");

    // overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(10);
    apply(11, 18, "ovr");

    // fill FIFO, then pop on the exact edge the 5th byte is pushed
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge CLOCK_50);
      rxd = fbit(8'h05, 1'b1, k);
      if (k == 10 * DIV - 3) begin cs = 1'b1; rw = 1'b1; adr = 2'd0; cpu_phi = 1'b1; end
      if (k == 10 * DIV - 2) begin cpu_phi = 1'b0; d = dbo; end
      if (k == 10 * DIV - 1) cs = 1'b0;
    end
    check("pushpop head", d, 8'h01);
    idle(10);
    apply(19, 24, "pushpop");

    // framing error, line held low afterwards
    send_frame(8'hF0, 1'b0);
    idle(40);
    rxd = 1'b1;
    idle(20);
    apply(29, 31, "ferr");

    // 2-cycle low glitch
    @(negedge CLOCK_50); rxd = 1'b0;
    @(negedge CLOCK_50); rxd = 1'b0;
    @(negedge CLOCK_50); rxd = 1'b1;
    idle(30);
    apply(32, 33, "glitch");

    // RX interrupt timing
    bus_wr(2'd2, 8'h01);
    @(negedge CLOCK_50); cs = 1'b1; rw = 1'b1; adr = 2'd1;
    fork
      send_frame(8'h55, 1'b1);
      for (int i = 0; i < 100; i++) begin
        @(posedge CLOCK_50); #1;
        rx_hist[i]  = dbo[0];
        irq_hist[i] = irq_n;
      end
    join
    cs = 1'b0;
    first = -1;
    for (int i = 0; i < 99; i++) if (first < 0 && rx_hist[i] === 1'b1) first = i;
    if (first < 0) check("irq rxav seen", 8'h00, 8'h01);
    else begin
      check("irq_n with rxav edge", {7'b0, irq_hist[first]}, 8'h01);
      check("irq_n one cycle later", {7'b0, irq_hist[first+1]}, 8'h00);
    end
    bus_rd(2'd0, d);
    check("irq data", d, 8'h55);
    check("irq_n at pop edge", {7'b0, irq_n}, 8'h00);
    @(negedge CLOCK_50);
    check("irq_n after pop", {7'b0, irq_n}, 8'h01);

    // TX-empty interrupt
    bus_wr(2'd2, 8'h02);
    check("txie irq_n at write edge", {7'b0, irq_n}, 8'h01);
    @(negedge CLOCK_50);
    check("txie irq_n", {7'b0, irq_n}, 8'h00);
    bus_wr(2'd2, 8'h00);
    idle(2);
    check("irq_n cleared", {7'b0, irq_n}, 8'h01);

    // reset mid TX frame
    bus_wr(2'd0, 8'h00);
    idle(30);
    check("midtx txd low", {7'b0, txd}, 8'h00);
    res_n = 1'b0;
    @(posedge CLOCK_50); #1;
    check("midtx txd at reset", {7'b0, txd}, 8'h01);
    idle(3);
    res_n = 1'b1;
    bus_rd(2'd1, d);
    check("midtx status", d, 8'h02);
    idle(5);
    check("midtx txd idle", {7'b0, txd}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
